// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg
// Shared constants for the shared-multiplier arbiter slice.
//   N_DEF    : default operand width (product is 2*N bits)
//   NREQ_DEF : default number of requesters
//   CNT_W    : width of the consumed-result counter
//   idw()    : width of a requester index, never less than 1 bit
package mul_arb_pkg;

  localparam int N_DEF    = 8;
  localparam int NREQ_DEF = 4;
  localparam int CNT_W    = 16;

  // A single requester still needs a 1-bit id field.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acc_mul.sv
// acc_mul
// Purely combinational unsigned multiplier shared by all requesters.
//   i_a : operand a, N bits
//   i_b : operand b, N bits
//   o_p : exact unsigned product, 2*N bits
module acc_mul #(
  parameter int N = 8
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  // Both operands are widened first so the product is not truncated.
  assign o_p = (2*N)'(i_a) * (2*N)'(i_b);

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb
// Round-robin arbiter that time-shares one acc_mul among NREQ requesters
// and holds each product in a single-entry result register.
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   req_valid : per-requester request strobe
//   req_a     : flat bus of operand a, slice i belongs to requester i
//   req_b     : flat bus of operand b, slice i belongs to requester i
//   req_ready : one-hot (or zero) grant, requester i accepted this cycle
//   res_valid : result register holds a product
//   res_ready : consumer takes the result this cycle
//   res_c     : product of the granted pair
//   res_id    : index of the requester that owns res_c
//   done_cnt  : count of consumed results, wraps at 2^CNT_W
module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = idw(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*N-1:0]    res_c,
  output logic [IDW-1:0]    res_id,
  output logic [CNT_W-1:0]  done_cnt
);

  logic              r_resValid;
  logic [2*N-1:0]    r_resC;
  logic [IDW-1:0]    r_resId;
  logic [IDW-1:0]    r_rrPtr;
  logic [CNT_W-1:0]  r_doneCnt;

  logic              w_slotFree;
  logic              w_found;
  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_gntIdx;
  logic [N-1:0]      w_a;
  logic [N-1:0]      w_b;
  logic [2*N-1:0]    w_prod;
  logic              w_consume;

  assign w_slotFree = !r_resValid || res_ready;
  assign w_consume  = r_resValid && res_ready;

  // Round-robin search starting at r_rrPtr. Only request strobes and slot
  // state feed the grant, so req_ready never depends on operand data.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    int idx;
    idx      = 0;
    w_grant  = '0;
    w_gntIdx = '0;
    w_found  = 1'b0;
    if (rst_n && w_slotFree) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(r_rrPtr) + k) % NREQ;
        if (!w_found && req_valid[idx]) begin
          w_found      = 1'b1;
          w_gntIdx     = IDW'(idx);
          w_grant[idx] = 1'b1;
        end
      end
    end
  end

  // Operand mux in front of the single shared multiplier.
  assign w_a = req_a[int'(w_gntIdx)*N +: N];
  assign w_b = req_b[int'(w_gntIdx)*N +: N];

  acc_mul #(.N(N)) u_accMul (
    .i_a (w_a),
    .i_b (w_b),
    .o_p (w_prod)
  );

  // A new grant overwrites the slot in the same edge the old result is
  // consumed, giving one result per cycle; without a grant a consumed
  // slot simply empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resValid <= 1'b0;
      r_resC     <= '0;
      r_resId    <= '0;
      r_rrPtr    <= '0;
      r_doneCnt  <= '0;
    end else begin
      if (w_found) begin
        r_resValid <= 1'b1;
        r_resC     <= w_prod;
        r_resId    <= w_gntIdx;
        r_rrPtr    <= IDW'((int'(w_gntIdx) + 1) % NREQ);
      end else if (w_consume) begin
        r_resValid <= 1'b0;
      end
      if (w_consume) begin
        r_doneCnt <= r_doneCnt + 1'b1;
      end
    end
  end

  assign req_ready = w_grant;
  assign res_valid = r_resValid;
  assign res_c     = r_resC;
  assign res_id    = r_resId;
  assign done_cnt  = r_doneCnt;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb
// Directed testbench for mul_share_arb at N=8, NREQ=4. Inputs change on the
// falling edge; req_ready is sampled 1 ns later, registered outputs 1 ns
// after the rising edge.
module tb_mul_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_c;
  logic [1:0]  res_id;
  logic [15:0] done_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_share_arb #(.N(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_c     (res_c),
    .res_id    (res_id),
    .done_cnt  (done_cnt)
  );

  task automatic setOp(input int idx, input logic [7:0] a, input logic [7:0] b);
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b1111; res_ready = 1'b1;
    req_a = 32'h0102_0304; req_b = 32'h0506_0708;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rst_ready got=%b exp=0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%b exp=0", res_valid); end
    checks++; if (res_c !== 16'd0) begin errors++; $display("[TB] FAIL rst_c got=%0d exp=0", res_c); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("[TB] FAIL rst_id got=%0d exp=0", res_id); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_cnt got=%0d exp=0", done_cnt); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
  endtask

  task automatic test_single();
    doReset();
    req_valid = 4'b0001; res_ready = 1'b1; setOp(0, 8'd143, 8'd227);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got=%b exp=0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got=%b exp=1", res_valid); end
    checks++; if (res_c !== 16'd32461) begin errors++; $display("[TB] FAIL single_c got=%0d exp=32461", res_c); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("[TB] FAIL single_id got=%0d exp=0", res_id); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (done_cnt !== 16'd1) begin errors++; $display("[TB] FAIL single_cnt got=%0d exp=1", done_cnt); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_clear got=%b exp=0", res_valid); end
  endtask

  task automatic test_all_four();
    logic [15:0] expC [4];
    expC[0] = 16'd200; expC[1] = 16'd1200; expC[2] = 16'd3000; expC[3] = 16'd50000;
    doReset();
    setOp(0, 8'd10, 8'd20); setOp(1, 8'd30, 8'd40);
    setOp(2, 8'd50, 8'd60); setOp(3, 8'd200, 8'd250);
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) begin
        @(negedge clk);
        req_valid[g-1] = 1'b0;
      end
      #1;
      checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("[TB] FAIL all4_ready%0d got=%b exp=%b", g, req_ready, 4'(1 << g)); end
      @(posedge clk); #1;
      checks++; if (res_c !== expC[g] || res_id !== 2'(g)) begin errors++; $display("[TB] FAIL all4_res%0d got=%0d/id%0d exp=%0d/id%0d", g, res_c, res_id, expC[g], g); end
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (done_cnt !== 16'd4) begin errors++; $display("[TB] FAIL all4_cnt got=%0d exp=4", done_cnt); end
  endtask

  task automatic test_backpressure();
    doReset();
    res_ready = 1'b0; req_valid = 4'b0001; setOp(0, 8'd12, 8'd13);
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1 || res_c !== 16'd156) begin errors++; $display("[TB] FAIL bp_first got=%b/%0d exp=1/156", res_valid, res_c); end
    @(negedge clk);
    req_valid = 4'b0100; setOp(2, 8'd9, 8'd9);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready%0d got=%b exp=0000", i, req_ready); end
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1 || res_c !== 16'd156 || res_id !== 2'd0) begin errors++; $display("[TB] FAIL bp_hold%0d got=%b/%0d/id%0d exp=1/156/id0", i, res_valid, res_c, res_id); end
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_release got=%b exp=0100", req_ready); end
    @(posedge clk); #1;
    checks++; if (res_c !== 16'd81 || res_id !== 2'd2 || done_cnt !== 16'd1) begin errors++; $display("[TB] FAIL bp_next got=%0d/id%0d/cnt%0d exp=81/id2/cnt1", res_c, res_id, done_cnt); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask

  task automatic test_fairness();
    logic [3:0] expG [4];
    int waitCycles;
    bit seen;
    expG[0] = 4'b0010; expG[1] = 4'b1000; expG[2] = 4'b0010; expG[3] = 4'b1000;
    doReset();
    setOp(1, 8'd2, 8'd3); setOp(3, 8'd4, 8'd5); setOp(0, 8'd6, 8'd7);
    req_valid = 4'b1010; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (req_ready !== expG[i]) begin errors++; $display("[TB] FAIL fair_grant%0d got=%b exp=%b", i, req_ready, expG[i]); end
      @(posedge clk);
    end
    #1;
    checks++; if (res_c !== 16'd20 || res_id !== 2'd3) begin errors++; $display("[TB] FAIL fair_res got=%0d/id%0d exp=20/id3", res_c, res_id); end
    @(negedge clk);
    req_valid = 4'b1011;
    waitCycles = 0; seen = 1'b0;
    while (!seen && waitCycles < 4) begin
      #1;
      if (req_ready[0]) seen = 1'b1;
      @(posedge clk);
      waitCycles++;
      if (!seen) @(negedge clk);
    end
    #1;
    checks++; if (!seen || res_id !== 2'd0 || res_c !== 16'd42) begin errors++; $display("[TB] FAIL fair_req0 got=seen%0d/id%0d/%0d exp=seen1/id0/42", seen, res_id, res_c); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    doReset();
    res_ready = 1'b0; req_valid = 4'b0010; setOp(1, 8'd100, 8'd100);
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1 || res_c !== 16'd10000) begin errors++; $display("[TB] FAIL mid_pre got=%b/%0d exp=1/10000", res_valid, res_c); end
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b0101; setOp(0, 8'd3, 8'd3); setOp(2, 8'd15, 8'd17);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL mid_ready got=%b exp=0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || res_c !== 16'd0 || res_id !== 2'd0 || done_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_clear got=%b/%0d/id%0d/cnt%0d exp=0/0/id0/cnt0", res_valid, res_c, res_id, done_cnt); end
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_resume got=%b exp=0001", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    checks++; if (res_id !== 2'd2 || res_c !== 16'd255) begin errors++; $display("[TB] FAIL mid_req2 got=id%0d/%0d exp=id2/255", res_id, res_c); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    doReset();
    for (int i = 0; i < 4; i++) setOp(i, 8'd255, 8'd255);
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_c !== 16'd65025) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL wrap_prod got=%0d bad exp=0", bad); end
    checks++; if (done_cnt !== 16'd65535) begin errors++; $display("[TB] FAIL wrap_pre got=%0d exp=65535", done_cnt); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (done_cnt !== 16'd0 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_cnt got=%0d/v%b exp=0/v0", done_cnt, res_valid); end
  endtask

  task automatic test_random();
    int bad, idx;
    logic [7:0] a, b;
    bad = 0;
    doReset();
    res_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (i > 0) @(negedge clk);
      idx = $urandom_range(0, 3);
      a = 8'($urandom); b = 8'($urandom);
      setOp(idx, a, b);
      req_valid = 4'(1 << idx);
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_c !== 16'(a) * 16'(b) || res_id !== 2'(idx)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL random_prod got=%0d bad exp=0", bad); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (done_cnt !== 16'd10000) begin errors++; $display("[TB] FAIL random_cnt got=%0d exp=10000", done_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 Parameter N, default 8: operand width; product width is 2*N.
REQ-002 Parameter NREQ, default 4: number of requesters; IDW = clog2(NREQ), minimum 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NREQ  bit i: requester i presents an operand pair.
REQ-006 req_a  input  NREQ*N  flat bus; slice i = operand a of requester i.
REQ-007 req_b  input  NREQ*N  flat bus; slice i = operand b of requester i.
REQ-008 req_ready  output  NREQ  one-hot or zero; bit i: requester i accepted this cycle.
REQ-009 res_valid  output  1  result register holds a valid product.
REQ-010 res_ready  input  1  consumer accepts the result this cycle.
REQ-011 res_c  output  2*N  product of the accepted pair.
REQ-012 res_id  output  IDW  index of the requester that owns res_c.
REQ-013 done_cnt  output  16  count of results consumed (res_valid && res_ready).

Function
REQ-014 The block SHALL share one combinational acc_mul instance among all requesters.
REQ-015 A slot is free when !res_valid || res_ready; transfers SHALL be considered only when the slot is free.
REQ-016 When the slot is free, grant SHALL go to the first requester with req_valid set, searching from rr_ptr upward modulo NREQ.
REQ-017 req_ready SHALL equal the grant vector, be combinational from req_valid, res_valid, res_ready and rr_ptr, and never depend on req_a or req_b.
REQ-018 On grant to requester g at edge k, res_c SHALL become a_g*b_g (exact, 2*N bits, unsigned), res_id SHALL become g, and res_valid SHALL become 1; latency is 1 cycle.
REQ-019 On grant to g, rr_ptr SHALL become (g+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-020 When res_valid=1 and res_ready=0, res_valid, res_c and res_id SHALL hold stable, and req_ready SHALL be all zero.
REQ-021 When res_valid=1, res_ready=1 and a request is pending, consume and accept SHALL occur in the same cycle; throughput is 1 result per cycle.
REQ-022 When res_valid=1, res_ready=1 and no request is pending, res_valid SHALL clear at the next edge.
REQ-023 Requesters SHALL hold req_valid and operands until req_ready is seen; the block SHALL NOT drop or duplicate a request.
REQ-024 done_cnt SHALL increment by 1 on each consume and wrap from 65535 to 0.
REQ-025 The product for a grant with req_a or req_b equal to 0 SHALL be 0; 255*255 SHALL give 65025 at N=8.

Reset
REQ-026 With rst_n=0 at an edge, res_valid, res_c, res_id, rr_ptr and done_cnt SHALL clear to 0.
REQ-027 While rst_n=0, req_ready SHALL be all zero.
REQ-028 A result in flight at reset SHALL be discarded with no consume counted.
REQ-029 Arbitration SHALL resume at requester 0 in the first cycle after rst_n returns to 1.

Structure
REQ-030 Package mul_arb_pkg SHALL hold the defaults for N and NREQ, the IDW function, and the done_cnt width constant (16).
REQ-031 The only sub-module SHALL be the existing acc_mul, instantiated once with N passed through.
REQ-032 The operand mux, round-robin grant logic and result register SHALL be local to mul_share_arb.

Verification
REQ-033 Single request: req_valid=0001, a=143, b=227, res_ready=1 -> next cycle res_valid=1, res_c=32461, res_id=0, done_cnt=1.
REQ-034 All four requesters valid, with distinct operands and res_ready=1 from reset -> grant order 0,1,2,3, one per cycle, with correct products and res_id.
REQ-035 Backpressure: hold res_ready=0 for 5 cycles after a grant -> res_c and res_id stable, req_ready=0; when res_ready rises, the next grant occurs in that same cycle.
REQ-036 Fairness: requesters 1 and 3 valid continuously -> grants alternate 1,3,1,3; req 0 raised mid-stream is granted within NREQ cycles.
REQ-037 Reset mid-operation: rst_n=0 with res_valid=1 -> all outputs 0 next cycle; after release, pending req 2 is granted with res_id=2.
REQ-038 Counter wrap: 65536 consumes of a=255, b=255 -> every res_c=65025 and done_cnt=0 at the end; random 10000-pair run matches a*b.
